pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the 5-stage CPU (first use: ID->EX).

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_slot.sv | 54 +++++
 rtl/pipe_stage_reg.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU inter-stage pipeline registers: control-word
// layout, the bubble encoding and a helper for spotting side-effecting controls.
package pipe_pkg;

  localparam int CTRL_W = 12;

  localparam int MEMWR      = 0;
  localparam int BRANCH     = 1;
  localparam int JUMP       = 2;
  localparam int MEMTOREG   = 3;
  localparam int REGWR      = 4;
  localparam int ALUASRC    = 5;
  localparam int ALUBSRC_LO = 6;
  localparam int ALUBSRC_HI = 7;
  localparam int ALUCTR_LO  = 8;
  localparam int ALUCTR_HI  = 11;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  typedef struct packed {
    logic [3:0] alu_ctr;
    logic [1:0] alu_b_src;
    logic       alu_a_src;
    logic       reg_wr;
    logic       mem_to_reg;
    logic       jump;
    logic       branch;
    logic       mem_wr;
  } ctrl_t;

  // True when a control word would change architectural state or redirect fetch.
  function automatic logic has_side_effect(input logic [CTRL_W-1:0] ctrl);
    return ctrl[REGWR] | ctrl[MEMWR] | ctrl[BRANCH] | ctrl[JUMP];
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: a valid bit plus its payload. Reset clears everything,
// flush kills the entry and zeroes its control word, load captures a new entry.
module pipe_slot #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 6,
  parameter int CTRL_W = 12
) (
  input  logic              CLK,
  input  logic              Resetn,
  input  logic              flush,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] nxt_pc,
  input  logic [DATA_W-1:0] nxt_busA,
  input  logic [DATA_W-1:0] nxt_busB,
  input  logic [DATA_W-1:0] nxt_imm,
  input  logic [RD_W-1:0]   nxt_rd,
  input  logic [CTRL_W-1:0] nxt_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic [DATA_W-1:0] imm,
  output logic [RD_W-1:0]   rd,
  output logic [CTRL_W-1:0] ctrl
);

  // The whole CPU pipeline updates on the falling edge.
  always_ff @(negedge CLK) begin
    if (!Resetn) begin
      valid <= 1'b0;
      pc    <= '0;
      busA  <= '0;
      busB  <= '0;
      imm   <= '0;
      rd    <= '0;
      ctrl  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= nxt_pc;
      busA  <= nxt_busA;
      busB  <= nxt_busB;
      imm   <= nxt_imm;
      rd    <= nxt_rd;
      ctrl  <= nxt_ctrl;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and an
// optional skid entry that makes in_ready a pure flop output.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 6,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              CLK,
  input  logic              Resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_busA,
  input  logic [DATA_W-1:0] in_busB,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_busA,
  output logic [DATA_W-1:0] out_busB,
  output logic [DATA_W-1:0] out_imm,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  import pipe_pkg::*;

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_pc, m_busA, m_busB, m_imm;
  logic [RD_W-1:0]   m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] s_pc, s_busA, s_busB, s_imm;
  logic [RD_W-1:0]   s_rd;
  logic [CTRL_W-1:0] s_ctrl;

  logic              accept, fire, m_load, m_clear;
  logic [DATA_W-1:0] src_pc, src_busA, src_busB, src_imm;
  logic [RD_W-1:0]   src_rd;
  logic [CTRL_W-1:0] src_ctrl;

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  // A waiting skid entry is always older than the input, so it refills the head first.
  assign src_pc   = s_valid ? s_pc   : in_pc;
  assign src_busA = s_valid ? s_busA : in_busA;
  assign src_busB = s_valid ? s_busB : in_busB;
  assign src_imm  = s_valid ? s_imm  : in_imm;
  assign src_rd   = s_valid ? s_rd   : in_rd;
  assign src_ctrl = s_valid ? s_ctrl : in_ctrl;

  pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_main (
    .CLK      (CLK),
    .Resetn   (Resetn),
    .flush    (flush),
    .load     (m_load),
    .clear    (m_clear),
    .nxt_pc   (src_pc),
    .nxt_busA (src_busA),
    .nxt_busB (src_busB),
    .nxt_imm  (src_imm),
    .nxt_rd   (src_rd),
    .nxt_ctrl (src_ctrl),
    .valid    (m_valid),
    .pc       (m_pc),
    .busA     (m_busA),
    .busB     (m_busB),
    .imm      (m_imm),
    .rd       (m_rd),
    .ctrl     (m_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic s_load, s_clear;

      // in_ready comes straight from the skid valid flop: no path from out_ready.
      assign in_ready = ~s_valid;

      always_comb begin
        m_load  = 1'b0;
        m_clear = 1'b0;
        s_load  = 1'b0;
        s_clear = 1'b0;
        if (!m_valid || fire) begin
          m_load  = s_valid | accept;
          m_clear = ~(s_valid | accept);
          s_load  = s_valid & accept;
          s_clear = ~(s_valid & accept);
        end else begin
          s_load  = accept;
        end
      end

      pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_skid (
        .CLK      (CLK),
        .Resetn   (Resetn),
        .flush    (flush),
        .load     (s_load),
        .clear    (s_clear),
        .nxt_pc   (in_pc),
        .nxt_busA (in_busA),
        .nxt_busB (in_busB),
        .nxt_imm  (in_imm),
        .nxt_rd   (in_rd),
        .nxt_ctrl (in_ctrl),
        .valid    (s_valid),
        .pc       (s_pc),
        .busA     (s_busA),
        .busB     (s_busB),
        .imm      (s_imm),
        .rd       (s_rd),
        .ctrl     (s_ctrl)
      );
    end else begin : g_single
      assign in_ready = ~m_valid | out_ready;
      assign m_load   = accept;
      assign m_clear  = fire & ~accept;
      assign s_valid  = 1'b0;
      assign s_pc     = '0;
      assign s_busA   = '0;
      assign s_busB   = '0;
      assign s_imm    = '0;
      assign s_rd     = '0;
      assign s_ctrl   = '0;
    end
  endgenerate

  assign out_valid = m_valid;
  assign out_pc    = m_pc;
  assign out_busA  = m_busA;
  assign out_busB  = m_busB;
  assign out_imm   = m_imm;
  assign out_rd    = m_rd;
  // A bubble must never carry RegWr/MemWr/Branch/Jump downstream.
  assign out_ctrl  = m_valid ? m_ctrl : CTRL_W'(CTRL_NOP);
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance,
// exercised in turn with streaming, stall, flush, flush+fire and reset cases.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int RW = 6;
  localparam int CW = 12;

  logic          CLK = 1'b0;
  logic          Resetn = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          iv1 = 1'b0, iv0 = 1'b0;
  logic [DW-1:0] in_pc = '0, in_busA = '0, in_busB = '0, in_imm = '0;
  logic [RW-1:0] in_rd = '0;
  logic [CW-1:0] in_ctrl = '0;

  logic          ir1, ov1, ir0, ov0;
  logic [DW-1:0] op1, oa1, ob1, oi1, op0, oa0, ob0, oi0;
  logic [RW-1:0] ord1, ord0;
  logic [CW-1:0] oc1, oc0;
  logic [1:0]    occ1, occ0;

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.DATA_W(DW), .RD_W(RW), .CTRL_W(CW), .SKID(1)) u_skid1 (
    .CLK(CLK), .Resetn(Resetn), .flush(flush), .in_valid(iv1), .in_ready(ir1),
    .in_pc(in_pc), .in_busA(in_busA), .in_busB(in_busB), .in_imm(in_imm),
    .in_rd(in_rd), .in_ctrl(in_ctrl), .out_valid(ov1), .out_ready(out_ready),
    .out_pc(op1), .out_busA(oa1), .out_busB(ob1), .out_imm(oi1),
    .out_rd(ord1), .out_ctrl(oc1), .occupancy(occ1));

  pipe_stage_reg #(.DATA_W(DW), .RD_W(RW), .CTRL_W(CW), .SKID(0)) u_skid0 (
    .CLK(CLK), .Resetn(Resetn), .flush(flush), .in_valid(iv0), .in_ready(ir0),
    .in_pc(in_pc), .in_busA(in_busA), .in_busB(in_busB), .in_imm(in_imm),
    .in_rd(in_rd), .in_ctrl(in_ctrl), .out_valid(ov0), .out_ready(out_ready),
    .out_pc(op0), .out_busA(oa0), .out_busB(ob0), .out_imm(oi0),
    .out_rd(ord0), .out_ctrl(oc0), .occupancy(occ0));

  typedef struct {
    logic [31:0] pc;
    int          t;
  } ent_t;

  ent_t        exq[$];
  logic [31:0] src[$];
  int          total = 0, bad = 0, tick_no = 0, delivered = 0;
  logic        sel = 1'b1, strict_lat = 1'b0;

  logic          g_ir, g_ov;
  logic [DW-1:0] g_pc, g_a, g_b, g_i;
  logic [RW-1:0] g_rd;
  logic [CW-1:0] g_ctrl;
  logic [1:0]    g_occ;

  function automatic logic [31:0] f_a(input logic [31:0] p);
    return p ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [31:0] f_b(input logic [31:0] p);
    return ~p;
  endfunction
  function automatic logic [31:0] f_i(input logic [31:0] p);
    return p + 32'h100;
  endfunction
  function automatic logic [5:0] f_rd(input logic [31:0] p);
    return p[7:2];
  endfunction
  function automatic logic [11:0] f_ctrl(input logic [31:0] p);
    return {4'h8, p[7:0]} | 12'h010;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s skid=%0d got=%h exp=%h (tick %0d)", tag, sel, got, exp, tick_no);
    end
  endtask

  task automatic sample();
    g_ir   = sel ? ir1  : ir0;
    g_ov   = sel ? ov1  : ov0;
    g_pc   = sel ? op1  : op0;
    g_a    = sel ? oa1  : oa0;
    g_b    = sel ? ob1  : ob0;
    g_i    = sel ? oi1  : oi0;
    g_rd   = sel ? ord1 : ord0;
    g_ctrl = sel ? oc1  : oc0;
    g_occ  = sel ? occ1 : occ0;
  endtask

  // Drive one cycle at the rising edge, check at +2, update the model for the falling edge.
  task automatic tick(input logic rdy, input logic fl);
    logic        v, acc, fire, exp_ir;
    logic [31:0] p;
    ent_t        e;
    @(posedge CLK);
    tick_no++;
    v         = (src.size() != 0);
    p         = v ? src[0] : 32'h0;
    in_pc     = p;
    in_busA   = f_a(p);
    in_busB   = f_b(p);
    in_imm    = f_i(p);
    in_rd     = f_rd(p);
    in_ctrl   = f_ctrl(p);
    out_ready = rdy;
    flush     = fl;
    iv1       = sel & v;
    iv0       = ~sel & v;
    #2;
    sample();
    exp_ir = sel ? (exq.size() < 2) : ((exq.size() == 0) || rdy);
    chk("occupancy", 32'(g_occ), 32'(exq.size()));
    chk("out_valid", 32'(g_ov), 32'(exq.size() != 0));
    chk("in_ready", 32'(g_ir), 32'(exp_ir));
    if (!g_ov) chk("bubble_ctrl", 32'(g_ctrl), 32'h0);
    fire = g_ov & rdy;
    acc  = v & g_ir;
    if (fire && exq.size() != 0) begin
      e = exq.pop_front();
      chk("out_pc", g_pc, e.pc);
      chk("out_busA", g_a, f_a(e.pc));
      chk("out_busB", g_b, f_b(e.pc));
      chk("out_imm", g_i, f_i(e.pc));
      chk("out_rd", 32'(g_rd), 32'(f_rd(e.pc)));
      chk("out_ctrl", 32'(g_ctrl), 32'(f_ctrl(e.pc)));
      if (strict_lat) chk("latency", 32'(tick_no - e.t), 32'd1);
      delivered++;
    end
    if (fl) begin
      exq.delete();
      src.delete();
    end else if (acc) begin
      e.pc = p;
      e.t  = tick_no;
      exq.push_back(e);
      void'(src.pop_front());
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (exq.size() != 0 || src.size() != 0); n++) tick(1'b1, 1'b0);
    chk("drain_left", 32'(exq.size() + src.size()), 32'd0);
  endtask

  task automatic run_suite(input logic s);
    int d0;
    sel = s;
    // Back-to-back stream, one-cycle latency, no gaps.
    d0 = delivered;
    strict_lat = 1'b1;
    src = '{32'h0, 32'h4, 32'h8, 32'hC};
    repeat (6) tick(1'b1, 1'b0);
    strict_lat = 1'b0;
    chk("stream_count", 32'(delivered - d0), 32'd4);
    // Stall with three pending entries, then release.
    src = '{32'h20, 32'h24, 32'h28};
    repeat (3) tick(1'b0, 1'b0);
    chk("stall_head", g_pc, 32'h20);
    chk("stall_occ", 32'(g_occ), sel ? 32'd2 : 32'd1);
    drain();
    // Flush from a full stage with a new entry presented.
    src = '{32'h30, 32'h34};
    repeat (3) tick(1'b0, 1'b0);
    src.push_back(32'h40);
    tick(~sel, 1'b1);
    tick(1'b1, 1'b0);
    chk("flush_occ", 32'(g_occ), 32'd0);
    chk("flush_ctrl", 32'(g_ctrl), 32'd0);
    // Flush in the same cycle as a delivery.
    src = '{32'h50};
    tick(1'b1, 1'b0);
    d0 = delivered;
    tick(1'b1, 1'b1);
    chk("flush_fire_delivered", 32'(delivered - d0), 32'd1);
    tick(1'b1, 1'b0);
    chk("flush_fire_empty", 32'(g_ov), 32'd0);
    // Reset while an entry is held.
    src = '{32'h60};
    tick(1'b0, 1'b0);
    @(posedge CLK);
    iv1 = 1'b0;
    iv0 = 1'b0;
    flush = 1'b0;
    Resetn = 1'b0;
    @(posedge CLK);
    Resetn = 1'b1;
    #2;
    sample();
    exq.delete();
    src.delete();
    chk("rst_mid_occ", 32'(g_occ), 32'd0);
    chk("rst_mid_valid", 32'(g_ov), 32'd0);
    chk("rst_mid_pc", g_pc, 32'h0);
    chk("rst_mid_ctrl", 32'(g_ctrl), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    Resetn = 1'b0;
    iv1 = 1'b1;
    iv0 = 1'b1;
    in_pc = 32'h10;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    Resetn = 1'b1;
    iv1 = 1'b0;
    iv0 = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      sel = (k == 0);
      sample();
      chk("rst_valid", 32'(g_ov), 32'd0);
      chk("rst_ctrl", 32'(g_ctrl), 32'd0);
      chk("rst_occ", 32'(g_occ), 32'd0);
      chk("rst_ready", 32'(g_ir), 32'd1);
      chk("rst_pc", g_pc, 32'h0);
    end
    run_suite(1'b1);
    run_suite(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
